arqt_memoria_pipe: RTL and testbench
====================================

ARQT_MEMORIA_PIPE -- requirements
Module: arqt_memoria_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8 from 8 to 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, word-address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from read acceptance to readdatavalid; legal values are 1 and 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 zero-fills the whole array after reset, 0 skips the fill.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  DATA_WIDTH/8  per-byte write enable.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_WIDTH  write data.
- clken  in  1  global clock enable; low stalls the block.
- readdata  out  DATA_WIDTH  read data, valid only while readdatavalid = 1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  high means the request is not accepted.

Function
REQ-006 SHALL implement a two-state FSM with states CLEAR and READY.
REQ-007 SHALL leave reset in CLEAR when CLEAR_ON_RESET = 1, and in READY otherwise.
REQ-008 In CLEAR, SHALL write all-zero to one address per clken-high cycle.
- The fill counter runs 0 to DEPTH-1.
- After the DEPTH-1 write the FSM moves to READY on the next edge.
REQ-009 SHALL drive waitrequest = (state == CLEAR) | ~clken, combinationally.
REQ-010 SHALL accept a write when chipselect & write & ~waitrequest.
- Only bytes with byteenable[i] = 1 are updated.
- byteenable = 0 leaves the word unchanged.
REQ-011 SHALL accept a read when chipselect & read & ~write & ~waitrequest.
- When read and write are both high, the write is performed and no read is issued.
REQ-012 SHALL present read data READ_LATENCY cycles after acceptance.
- READ_LATENCY = 1: RAM output register only.
- READ_LATENCY = 2: one additional output register.
REQ-013 SHALL assert readdatavalid for exactly one cycle per accepted read, in order, with no drops or duplicates.
REQ-014 SHALL accept back-to-back reads on every cycle, giving sustained throughput of one word per cycle.
REQ-015 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-016 While clken = 0, SHALL freeze all state.
- Frozen state: RAM, fill counter, FSM, read pipeline, readdatavalid.
- readdata and readdatavalid hold their values.
- On resumption, pending reads complete with their remaining latency.
REQ-017 SHALL ignore address, byteenable and writedata when no request is accepted.
REQ-018 Address wrap: a fill counter at DEPTH-1 SHALL end the fill and SHALL NOT wrap to 0.

Reset
REQ-019 While reset_n = 0, SHALL force:
- readdatavalid = 0, readdata = 0.
- Read pipeline valid flags cleared.
- Fill counter = 0.
- FSM = CLEAR (CLEAR_ON_RESET = 1) or READY (CLEAR_ON_RESET = 0).
REQ-020 Reset asserted mid-fill or with reads in flight SHALL discard pending reads and SHALL restart the fill from address 0.
REQ-021 Array contents SHALL NOT be cleared asynchronously; only the CLEAR fill zeroes them.

Verification
REQ-022 Fill: defaults; release reset_n with clken = 1 -> waitrequest high for exactly 2048 cycles, then low; read of addr 0x7FF -> readdata = 0.
REQ-023 Byte write: write 0xDEADBEEF to 0x010 with byteenable 0xF, then 0x00000055 with byteenable 0x1 -> read of 0x010 returns 0xDEADBE55.
REQ-024 Latency: READ_LATENCY = 2; reads of 0x000..0x003 on 4 consecutive cycles -> 4 consecutive readdatavalid pulses starting 2 cycles after the first read, data in order.
REQ-025 Stall: clken = 0 for 3 cycles while one read is in flight -> waitrequest high throughout, readdatavalid delayed by exactly 3 cycles, data correct.
REQ-026 Reset mid-fill: reset_n low at fill count 100 -> readdatavalid = 0 immediately; after release, waitrequest high for 2048 cycles.
REQ-027 Read+write collision: read = write = 1 at 0x020 with data 0x12345678 -> no readdatavalid; a following read returns 0x12345678.

Source files
------------

// File: rtl/arqt_memoria_pipe.sv
// Byte-enabled single-port RAM slave that zero-fills itself after reset.
// Latency: readdatavalid READ_LATENCY (1 or 2) enabled cycles after a read is accepted.
// Backpressure: waitrequest holds off requests during the fill and while clken is low.
module arqt_memoria_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc, rd_acc, fill_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_vld;

  assign waitrequest = (state_q == CLEAR) | ~clken;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign fill_we     = (state_q == CLEAR) & clken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
    end else if (clken) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && fill_cnt == LAST_ADDR) begin
      state_d = READY;
    end
  end

  // Counter parks at the last address once the fill completes; it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt <= '0;
    end else if (fill_we && fill_cnt != LAST_ADDR) begin
      fill_cnt <= fill_cnt + ADDR_ONE;
    end
  end

  // Array has no reset so it can map onto block RAM; only the fill zeroes it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_cnt] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_vld <= 1'b0;
      ram_q   <= '0;
    end else if (clken) begin
      ram_vld <= rd_acc;
      if (rd_acc) begin
        ram_q <= mem[address];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_vld <= 1'b0;
        out_q   <= '0;
      end else if (clken) begin
        out_vld <= ram_vld;
        if (ram_vld) begin
          out_q <= ram_q;
        end
      end
    end

    assign readdata      = out_q;
    assign readdatavalid = out_vld;
  end else begin : g_lat1
    assign readdata      = ram_q;
    assign readdatavalid = ram_vld;
  end

endmodule

// File: tb/tb_arqt_memoria_pipe.sv
// Bench for arqt_memoria_pipe: latency-1 and latency-2 instances share stimulus and an aging-queue model.
module tb_arqt_memoria_pipe;
  logic        clk = 1'b0;
  logic        reset_n, chipselect, read, write, clken;
  logic [10:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rd1, rd2;
  logic        dv1, dv2, wt1, wt2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  arqt_memoria_pipe #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd1), .readdatavalid(dv1), .waitrequest(wt1));

  arqt_memoria_pipe #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd2), .readdatavalid(dv2), .waitrequest(wt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: array contents, remaining fill words, and reads aging by enabled edges.
  typedef struct { logic [31:0] d; int age; } rd_t;
  rd_t         pend[$];
  logic [31:0] mem_m [2048];
  int          fill_left = 2048;
  logic        ev1 = 1'b0, ev2 = 1'b0;
  logic [31:0] ed1 = '0, ed2 = '0;
  bit          m_busy;
  rd_t         m_ent;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_left = 2048;
      pend.delete();
      ev1 = 1'b0; ev2 = 1'b0; ed1 = '0; ed2 = '0;
    end else if (clken) begin
      m_busy = (fill_left > 0);
      foreach (pend[i]) pend[i].age++;
      while (pend.size() > 0 && pend[0].age > 2) void'(pend.pop_front());
      if (m_busy) begin
        mem_m[2048 - fill_left] = '0;
        fill_left--;
      end else if (chipselect && write) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem_m[address][b*8 +: 8] = writedata[b*8 +: 8];
      end else if (chipselect && read) begin
        m_ent.d = mem_m[address];
        m_ent.age = 1;
        pend.push_back(m_ent);
      end
      ev1 = 1'b0; ev2 = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].age == 1) begin ev1 = 1'b1; ed1 = pend[i].d; end
        if (pend[i].age == 2) begin ev2 = 1'b1; ed2 = pend[i].d; end
      end
    end
  end

  logic exp_w;
  always @(negedge clk) begin
    exp_w = (fill_left > 0) || !clken;
    chk("wait_l1", 32'(wt1), 32'(exp_w));
    chk("wait_l2", 32'(wt2), 32'(exp_w));
    chk("vld_l1", 32'(dv1), 32'(ev1));
    chk("vld_l2", 32'(dv2), 32'(ev2));
    if (ev1) chk("dat_l1", rd1, ed1);
    if (ev2) chk("dat_l2", rd2, ed2);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    step();
    idle();
  endtask

  task automatic read_chk(input logic [10:0] a, input logic [31:0] exp, input string nm);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
    idle();
    chk({nm, "_v1"}, 32'(dv1), 32'd1);
    chk({nm, "_d1"}, rd1, exp);
    step();
    chk({nm, "_v2"}, 32'(dv2), 32'd1);
    chk({nm, "_d2"}, rd2, exp);
  endtask

  task automatic fill_wait(input string nm);
    int n;
    n = 0;
    while (wt1 && n < 3000) begin
      n++;
      step();
    end
    chk(nm, n, 32'd2048);
  endtask

  logic [31:0] lat_val [4];
  int          n;

  initial begin
    reset_n = 1'b1; clken = 1'b1; idle();
    address = '0; byteenable = '0; writedata = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_vld_l1", 32'(dv1), 32'd0);
    chk("rst_vld_l2", 32'(dv2), 32'd0);
    chk("rst_dat_l1", rd1, 32'd0);
    chk("rst_wait", 32'(wt1), 32'd1);
    step(2);
    reset_n = 1'b1;
    fill_wait("fill_len");
    read_chk(11'h7FF, 32'h0, "fill_7ff");

    do_write(11'h010, 32'hDEADBEEF, 4'hF);
    do_write(11'h010, 32'h00000055, 4'h1);
    read_chk(11'h010, 32'hDEADBE55, "byte_wr");
    do_write(11'h010, 32'hFFFFFFFF, 4'h0);
    read_chk(11'h010, 32'hDEADBE55, "be_zero");

    // Four back-to-back reads; the latency-2 instance must pulse on four consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      lat_val[i] = 32'hA5000000 + 32'(i * 17);
      do_write(11'(i), lat_val[i], 4'hF);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 11'(i);
      end else begin
        idle();
      end
      step();
      if (i == 0 || i == 5) begin
        chk("lat_gap_v2", 32'(dv2), 32'd0);
      end else begin
        chk("lat_v2", 32'(dv2), 32'd1);
        chk("lat_d2", rd2, lat_val[i-1]);
      end
    end

    // One read in flight, then three stalled cycles.
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 11'h002;
    step();
    idle();
    clken = 1'b0;
    n = 1;
    while (!dv2 && n < 20) begin
      if (n == 4) begin
        chk("stall_wait", 32'(wt2), 32'd1);
        chk("stall_hold_v1", 32'(dv1), 32'd1);
        clken = 1'b1;
      end
      step();
      n++;
    end
    chk("stall_delay", n, 32'd5);
    chk("stall_dat", rd2, lat_val[2]);

    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 11'h020; writedata = 32'h12345678; byteenable = 4'hF;
    step();
    idle();
    chk("coll_v1", 32'(dv1), 32'd0);
    step();
    chk("coll_v2", 32'(dv2), 32'd0);
    read_chk(11'h020, 32'h12345678, "coll_rd");

    // Reset with a read in flight, then again partway through the fill.
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 11'h010;
    step();
    idle();
    reset_n = 1'b0;
    #1;
    chk("flight_v1", 32'(dv1), 32'd0);
    chk("flight_d1", rd1, 32'd0);
    chk("flight_v2", 32'(dv2), 32'd0);
    step();
    reset_n = 1'b1;
    step(100);
    reset_n = 1'b0;
    #1;
    chk("midfill_v1", 32'(dv1), 32'd0);
    chk("midfill_wait", 32'(wt1), 32'd1);
    step();
    reset_n = 1'b1;
    fill_wait("refill_len");
    read_chk(11'h010, 32'h0, "refilled");

    for (int i = 0; i < 3000; i++) begin
      chipselect = ($urandom_range(0, 9) < 8);
      read       = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 3) == 0);
      address    = 11'($urandom_range(0, 15));
      byteenable = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      clken      = ($urandom_range(0, 7) != 0);
      step();
    end
    clken = 1'b1;
    idle();
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
